// File: rtl/shift_scheduler.sv
// Round-robin arbiter in front of a shared rotate-left/rotate-right barrel
// shifter. One request is in flight at a time. Its result is held with the
// requester ID until the consumer takes it. A saturating counter records the
// number of completed responses.
module shift_scheduler #(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int AMT_W  = $clog2(DATA_W),
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ*DATA_W-1:0]   req_a_i,
    input  logic [N_REQ*AMT_W-1:0]    req_amt_i,
    input  logic [N_REQ-1:0]          req_sel_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [DATA_W-1:0]         resp_data_o,
    output logic [ID_W-1:0]           resp_id_o,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          op_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [DATA_W-1:0]   a_q;
    logic [AMT_W-1:0]    amt_q;
    logic                sel_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [ID_W-1:0]     resp_id_q;
    logic [CNT_W-1:0]    op_count_q;

    logic                found_d;
    logic [ID_W-1:0]     win_d;
    logic [ID_W:0]       idx_sum;
    logic [DATA_W-1:0]   win_a;
    logic [AMT_W-1:0]    win_amt;
    logic                win_sel;

    logic [2*DATA_W-1:0] rot_l_w;
    logic [2*DATA_W-1:0] rot_r_w;
    logic [DATA_W-1:0]   rot_res;

    // Round-robin search: scan from rr_ptr upward (mod N_REQ); the nearest
    // valid requester wins. Scanning from the far end lets the closest
    // candidate overwrite earlier ones, so no break is needed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        found_d = 1'b0;
        win_d   = '0;
        idx_sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_sum >= (ID_W+1)'(N_REQ)) begin
                idx_sum = idx_sum - (ID_W+1)'(N_REQ);
            end
            if (req_valid_i[idx_sum[ID_W-1:0]]) begin
                found_d = 1'b1;
                win_d   = idx_sum[ID_W-1:0];
            end
        end
    end

    assign win_a   = req_a_i[win_d*DATA_W +: DATA_W];
    assign win_amt = req_amt_i[win_d*AMT_W +: AMT_W];
    assign win_sel = req_sel_i[win_d];

    // Barrel shifter: shift a doubled copy of the operand so the bits pushed
    // out of one end come back in at the other end.
    always_comb begin
        rot_l_w = {a_q, a_q} << amt_q;
        rot_r_w = {a_q, a_q} >> amt_q;
        rot_res = sel_q ? rot_r_w[DATA_W-1:0] : rot_l_w[2*DATA_W-1:DATA_W];
    end

    // Grants are offered only in IDLE and are masked while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (reset_n && (state_q == S_IDLE) && found_d) begin
            req_ready_o = N_REQ'(1) << win_d;
        end
    end

    // Control FSM with registered response outputs. A reset aborts any
    // request that was captured but not yet accepted by the consumer.
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignment so every register
        // samples the pre-edge values, whatever order the statements run in.
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            a_q          <= '0;
            amt_q        <= '0;
            sel_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        a_q       <= win_a;
                        amt_q     <= win_amt;
                        sel_q     <= win_sel;
                        resp_id_q <= win_d;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_data_q  <= rot_res;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= (resp_id_q == ID_W'(N_REQ - 1)) ? '0
                                                                       : resp_id_q + ID_W'(1);
                        if (op_count_q != '1) begin
                            op_count_q <= op_count_q + CNT_W'(1);
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_id_o    = resp_id_q;
    assign op_count_o   = op_count_q;
    assign busy_o       = reset_n && (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_scheduler.sv
// Bench for shift_scheduler: directed cases with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_shift_scheduler;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int CW   = 4;
    localparam int IW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*AW-1:0] req_amt = '0;
    logic [N-1:0]    req_sel = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [DW-1:0]   resp_data;
    logic [IW-1:0]   resp_id;
    logic            busy;
    logic [CW-1:0]   op_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_scheduler #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_amt_i    (req_amt),
        .req_sel_i    (req_sel),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_id_o    (resp_id),
        .busy_o       (busy),
        .op_count_o   (op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rotation as a bit permutation: bit i moves to (i + left_amount) mod DW;
    // a right rotate by n is a left rotate by DW - n.
    function automatic logic [DW-1:0] rot(input logic [DW-1:0] a, input int amt, input bit right);
        int sh;
        logic [DW-1:0] r;
        sh = right ? (DW - amt) % DW : amt;
        r  = '0;
        for (int i = 0; i < DW; i++) r[(i + sh) % DW] = a[i];
        return r;
    endfunction

    // First valid requester at or after rr, wrapping; -1 when none.
    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    // Transaction-level model: at most one operation outstanding, identified
    // by its age in cycles since grant; the result is visible from age 2.
    int            m_rr  = 0;
    int            m_cnt = 0;
    bit            m_has = 1'b0;
    int            m_age = 0;
    int            m_id  = 0;
    logic [DW-1:0] m_res = '0;
    int            m_w;
    logic [N-1:0]  e_ready;
    bit            e_valid;

    // Every-cycle compare, then advance the model across the coming edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            m_w     = pick(req_valid, m_rr);
            e_ready = '0;
            if (reset_n && !m_has && m_w >= 0) e_ready[m_w] = 1'b1;
            e_valid = m_has && (m_age >= 2);
            check("m_ready", req_ready, e_ready);
            check("m_resp_valid", resp_valid, e_valid);
            check("m_busy", busy, reset_n && m_has);
            check("m_count", op_count, m_cnt);
            if (e_valid) begin
                check("m_data", resp_data, m_res);
                check("m_id", resp_id, m_id);
            end
            if (!reset_n) begin
                m_has = 1'b0;
                m_rr  = 0;
                m_cnt = 0;
            end else if (m_has) begin
                if (m_age >= 2) begin
                    if (resp_ready) begin
                        m_has = 1'b0;
                        m_rr  = (m_id + 1) % N;
                        if (m_cnt < CMAX) m_cnt++;
                    end
                end else begin
                    m_age++;
                end
            end else if (m_w >= 0) begin
                m_has = 1'b1;
                m_age = 1;
                m_id  = m_w;
                m_res = rot(req_a[m_w*DW +: DW], int'(req_amt[m_w*AW +: AW]), req_sel[m_w]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [DW-1:0] a, input int amt, input bit sel);
        req_a[id*DW +: DW]   = a;
        req_amt[id*AW +: AW] = AW'(amt);
        req_sel[id]          = sel;
        req_valid[id]        = 1'b1;
    endtask

    // One isolated operation with resp_ready held high.
    task automatic run_one(input int id, input logic [DW-1:0] a, input int amt, input bit sel,
                           input logic [DW-1:0] exp, input int exp_cnt);
        tick();
        req_valid = '0;
        set_req(id, a, amt, sel);
        settle();
        check("grant", req_ready, 32'd1 << id);
        tick();
        req_valid = '0;
        settle();
        check("exec_valid", resp_valid, 0);
        check("exec_busy", busy, 1);
        tick();
        settle();
        check("resp_valid", resp_valid, 1);
        check("resp_data", resp_data, exp);
        check("resp_id", resp_id, id);
        tick();
        settle();
        check("done_count", op_count, exp_cnt);
        check("done_valid", resp_valid, 0);
    endtask

    int           order [5] = '{0, 1, 2, 3, 0};
    int           g, last, cyc;
    logic [N-1:0] gnt = '0;

    initial begin
        // Reset with random request activity.
        reset_n    = 1'b0;
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            req_valid = N'($urandom);
            settle();
            check("rst_ready", req_ready, 0);
            check("rst_valid", resp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_count", op_count, 0);
            check("rst_data", resp_data, 0);
            check("rst_id", resp_id, 0);
        end
        tick();
        reset_n    = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;

        // Single requests: left/right rotates and amount boundaries.
        run_one(0, 8'h96, 3, 1'b0, 8'hB4, 1);
        run_one(1, 8'h81, 1, 1'b1, 8'hC0, 2);
        run_one(2, 8'h5A, 0, 1'b0, 8'h5A, 3);
        run_one(3, 8'h01, 7, 1'b0, 8'h80, 4);
        run_one(0, 8'h5A, 0, 1'b1, 8'h5A, 5);

        // All requesters valid continuously from reset.
        tick();
        reset_n   = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) set_req(i, DW'($urandom), $urandom_range(0, DW-1), 1'($urandom));
        tick();
        tick();
        reset_n = 1'b1;
        g = 0; last = 0; cyc = 0;
        while (g < 5 && cyc < 40) begin
            settle();
            if (req_ready != '0) begin
                check("rr_order", req_ready, 32'd1 << order[g]);
                if (g > 0) check("rr_spacing", cyc - last, 3);
                last = cyc;
                g++;
            end
            cyc++;
            tick();
        end
        if (g < 5) check("rr_timeout", g, 5);
        req_valid = '0;
        repeat (4) tick();

        // Backpressure: result and ID hold while the consumer stalls.
        resp_ready = 1'b0;
        set_req(1, 8'h3C, 2, 1'b1);
        set_req(3, 8'h11, 1, 1'b0);
        settle();
        check("bp_grant", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            settle();
            check("bp_valid", resp_valid, 1);
            check("bp_data", resp_data, 8'h0F);
            check("bp_id", resp_id, 1);
            check("bp_ready", req_ready, 0);
            check("bp_count", op_count, 5);
            tick();
        end
        resp_ready = 1'b1;
        settle();
        tick();
        settle();
        check("bp_next_grant", req_ready, 4'b1000);
        check("bp_count_after", op_count, 6);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset one cycle after a grant: the operation is dropped.
        run_one(0, 8'hF0, 4, 1'b0, 8'h0F, 8);
        tick();
        set_req(2, 8'hAA, 1, 1'b0);
        settle();
        check("rx_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        reset_n   = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("rx_valid", resp_valid, 0);
            check("rx_busy", busy, 0);
            check("rx_count", op_count, 0);
            tick();
        end
        req_valid = '1;
        settle();
        check("rx_rr_ptr", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Randomized traffic, occasional resets and drop-before-grant.
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset_n    = ($urandom_range(0, 399) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (gnt[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_req(i, DW'($urandom), $urandom_range(0, DW-1), 1'($urandom));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            settle();
            gnt = req_ready & req_valid;
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
